joy_serializer: RTL and testbench

Target-side emulator of the dual-joystick serial link. It models the parallel-in/serial-out shift register chain at the far end of the joystick port. It snapshots 16 switch levels (two 8-bit joysticks) while the host holds `joy_load_n` low, then presents one bit per host `joy_clk` rising edge on `joy_data`. Used for loopback test builds and for boards where local buttons must appear to the core as a serial joystick chain.

---
 rtl/joy_pkg.sv | 22 ++
 rtl/joy_sync_filter.sv | 57 +++++
 rtl/joy_serializer.sv | 101 ++++++++++
 tb/tb_joy_serializer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared constants for the dual-joystick serial link emulator.
package joy_pkg;

  // Joystick bit map, active-high pressed
  localparam int unsigned JOY_UP    = 7;
  localparam int unsigned JOY_DOWN  = 6;
  localparam int unsigned JOY_LEFT  = 5;
  localparam int unsigned JOY_RIGHT = 4;
  localparam int unsigned JOY_FIRE1 = 3;
  localparam int unsigned JOY_FIRE2 = 2;
  localparam int unsigned JOY_FIRE3 = 1;
  localparam int unsigned JOY_START = 0;

  localparam int unsigned JOY_FRAME_BITS = 16;
  // bit_cnt must hold 0..JOY_FRAME_BITS inclusive
  localparam int unsigned JOY_CNT_W = $clog2(JOY_FRAME_BITS + 1);

  localparam int unsigned JOY_FILTER_LEN_DEFAULT = 4;

  typedef logic [JOY_FRAME_BITS-1:0] joy_frame_t;

endpackage

// File: rtl/joy_sync_filter.sv
// 2-FF synchronizer followed by an N-sample glitch filter; emits the filtered
// level plus single-cycle rise/fall pulses derived from it.
module joy_sync_filter
  import joy_pkg::*;
#(
  parameter logic        RESET_VAL  = 1'b0,
  parameter int unsigned FILTER_LEN = JOY_FILTER_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       prev_q;
  logic [3:0] cnt_q, cnt_d;

  // Accept a new level only after FILTER_LEN consecutive differing samples
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == 4'(FILTER_LEN - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // Synchronizer, filter counter and edge-detect history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      level_q <= RESET_VAL;
      prev_q  <= RESET_VAL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Pulses are asserted in the first cycle the new filtered level is visible
  assign level = level_q;
  assign rise  = level_q & ~prev_q;
  assign fall  = ~level_q & prev_q;

endmodule

// File: rtl/joy_serializer.sv
// Target-side emulator of the dual-joystick parallel-in/serial-out chain.
module joy_serializer
  import joy_pkg::*;
#(
  parameter int unsigned FILTER_LEN = JOY_FILTER_LEN_DEFAULT,
  parameter logic        FILL_BIT   = 1'b0,
  parameter logic [19:0] TIMEOUT    = 20'd1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       joy_clk,
  input  logic       joy_load_n,
  input  logic [7:0] joy1,
  input  logic [7:0] joy2,
  output logic       joy_data,
  output logic       frame_done,
  output logic       link_idle
);

  logic                 clk_lvl_unused, clk_rise, clk_fall_unused;
  logic                 load_lvl, load_rise_unused, load_fall;

  joy_frame_t           joy_s1_q, joy_s2_q;
  joy_frame_t           shreg_q, shreg_d;
  logic [JOY_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic [19:0]          tmo_q, tmo_d;

  joy_sync_filter #(
    .RESET_VAL  (1'b0),
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filt (
    .clk   (clk),
    .rst   (rst),
    .din   (joy_clk),
    .level (clk_lvl_unused),
    .rise  (clk_rise),
    .fall  (clk_fall_unused)
  );

  joy_sync_filter #(
    .RESET_VAL  (1'b1),
    .FILTER_LEN (FILTER_LEN)
  ) u_load_filt (
    .clk   (clk),
    .rst   (rst),
    .din   (joy_load_n),
    .level (load_lvl),
    .rise  (load_rise_unused),
    .fall  (load_fall)
  );

  // Shift register, bit counter, frame-done and timeout next-state
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    if (!load_lvl) begin
      shreg_d   = joy_s2_q;
      bit_cnt_d = '0;
    end else if (clk_rise) begin
      shreg_d = {FILL_BIT, shreg_q[JOY_FRAME_BITS-1:1]};
      if (bit_cnt_q != JOY_CNT_W'(JOY_FRAME_BITS)) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    // bit_cnt is still the pre-load value in the load_fall cycle
    frame_done_d = load_fall && (bit_cnt_q >= JOY_CNT_W'(JOY_FRAME_BITS - 1));

    tmo_d = tmo_q;
    if (load_fall) begin
      tmo_d = '0;
    end else if (tmo_q != TIMEOUT) begin
      tmo_d = tmo_q + 20'd1;
    end
  end

  // State registers; timeout counter resets saturated so the link starts idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      joy_s1_q     <= '0;
      joy_s2_q     <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      tmo_q        <= TIMEOUT;
    end else begin
      joy_s1_q     <= {joy2, joy1};
      joy_s2_q     <= joy_s1_q;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_done_q <= frame_done_d;
      tmo_q        <= tmo_d;
    end
  end

  assign joy_data   = shreg_q[0];
  assign frame_done = frame_done_q;
  assign link_idle  = (tmo_q == TIMEOUT);

endmodule

// File: tb/tb_joy_serializer.sv
// Directed bench for joy_serializer with a simple host model.
module tb_joy_serializer;

  localparam int          HP  = 64;
  localparam logic [19:0] TMO = 20'd300;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       joy_clk = 1'b0;
  logic       joy_load_n = 1'b1;
  logic [7:0] joy1 = '0;
  logic [7:0] joy2 = '0;
  logic       joy_data, frame_done, link_idle;

  int tests  = 0;
  int failed = 0;
  int fd_cnt = 0;

  joy_serializer #(
    .FILTER_LEN (4),
    .FILL_BIT   (1'b0),
    .TIMEOUT    (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .joy_clk    (joy_clk),
    .joy_load_n (joy_load_n),
    .joy1       (joy1),
    .joy2       (joy2),
    .joy_data   (joy_data),
    .frame_done (frame_done),
    .link_idle  (link_idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic host_load(input logic [7:0] j1, input logic [7:0] j2);
    joy1 = j1;
    joy2 = j2;
    joy_load_n = 1'b0;
    wait_clk(HP);
    joy_load_n = 1'b1;
    wait_clk(HP);
  endtask

  task automatic host_shift();
    joy_clk = 1'b1;
    wait_clk(HP);
    joy_clk = 1'b0;
    wait_clk(HP);
  endtask

  // Sample bit 0, then n-1 times: rise, wait, fall, sample on the fall
  task automatic host_read(input int n, output logic [31:0] w);
    w = '0;
    w[0] = joy_data;
    for (int i = 1; i < n; i++) begin
      joy_clk = 1'b1;
      wait_clk(HP);
      joy_clk = 1'b0;
      w[i] = joy_data;
      wait_clk(HP);
    end
  endtask

  initial begin
    logic [31:0] w;
    int fd0, lat, idle_low;

    // Reset state
    wait_clk(4);
    check("rst_joy_data", 32'(joy_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_link_idle", 32'(link_idle), 32'd1);
    check("rst_bit_cnt", 32'(dut.bit_cnt_q), 32'd0);
    rst = 1'b0;
    wait_clk(10);

    // Basic frame
    host_load(8'h81, 8'h00);
    host_read(16, w);
    check("basic_word", w & 32'hFFFF, 32'h0081);
    host_shift();
    check("basic_cnt16", 32'(dut.bit_cnt_q), 32'd16);
    fd0 = fd_cnt;

    // Both sticks; this load ends the basic frame
    host_load(8'h5A, 8'hC3);
    check("basic_frame_done", 32'(fd_cnt - fd0), 32'd1);
    host_read(16, w);
    check("both_word", w & 32'hFFFF, 32'hC35A);
    check("both_bit0", 32'(w[0]), 32'd0);
    check("both_bit15", 32'(w[15]), 32'd1);
    fd0 = fd_cnt;

    // Glitch rejection: 2-cycle joy_clk pulses mid-bit
    host_load(8'h3C, 8'h96);
    check("fd_after_15_shifts", 32'(fd_cnt - fd0), 32'd1);
    w = '0;
    w[0] = joy_data;
    for (int i = 1; i < 16; i++) begin
      joy_clk = 1'b1;
      wait_clk(HP);
      joy_clk = 1'b0;
      w[i] = joy_data;
      wait_clk(30);
      joy_clk = 1'b1;
      wait_clk(2);
      joy_clk = 1'b0;
      wait_clk(HP - 32);
      if (i == 8) begin
        check("glitch_cnt", 32'(dut.bit_cnt_q), 32'd8);
        check("glitch_shreg", 32'(dut.shreg_q), 32'h0096);
      end
    end
    check("glitch_word", w & 32'hFFFF, 32'h963C);

    // Over-shift: 20 shifts total
    host_load(8'hA5, 8'hFF);
    host_read(20, w);
    host_shift();
    check("over_word", w & 32'hFFFF, 32'hFFA5);
    check("over_fill", (w >> 16) & 32'hF, 32'h0);
    check("over_cnt", 32'(dut.bit_cnt_q), 32'd16);
    check("over_data", 32'(joy_data), 32'd0);
    fd0 = fd_cnt;

    // Load priority: inputs change and joy_clk pulses while load is held
    joy_load_n = 1'b0;
    joy1 = 8'h11;
    wait_clk(20);
    joy1 = 8'h22;
    wait_clk(20);
    joy_clk = 1'b1;
    wait_clk(HP);
    joy1 = 8'h33;
    joy2 = 8'h44;
    joy_clk = 1'b0;
    wait_clk(HP);
    joy_load_n = 1'b1;
    wait_clk(HP);
    check("prio_fd", 32'(fd_cnt - fd0), 32'd1);
    check("prio_cnt", 32'(dut.bit_cnt_q), 32'd0);
    check("prio_shreg", 32'(dut.shreg_q), 32'h4433);
    host_read(16, w);
    check("prio_word", w & 32'hFFFF, 32'h4433);

    // Reset mid-frame and idle behaviour
    host_load(8'hFF, 8'h00);
    for (int i = 0; i < 5; i++) host_shift();
    check("pre_rst_data", 32'(joy_data), 32'd1);
    check("pre_rst_cnt", 32'(dut.bit_cnt_q), 32'd5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_data", 32'(joy_data), 32'd0);
    check("mid_rst_idle", 32'(link_idle), 32'd1);
    check("mid_rst_cnt", 32'(dut.bit_cnt_q), 32'd0);
    wait_clk(3);
    rst = 1'b0;
    fd0 = fd_cnt;
    idle_low = 0;
    for (int i = 0; i < int'(TMO) + 20; i++) begin
      @(negedge clk);
      if (link_idle !== 1'b1) idle_low++;
    end
    check("idle_hold", 32'(idle_low), 32'd0);
    joy_load_n = 1'b0;
    lat = 0;
    while (link_idle !== 1'b0 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("idle_fall_latency", 32'(lat), 32'd7);
    wait_clk(HP);
    joy_load_n = 1'b1;
    check("no_fd_after_rst", 32'(fd_cnt - fd0), 32'd0);
    wait_clk(int'(TMO) - 10 - HP);
    check("idle_before_tmo", 32'(link_idle), 32'd0);
    wait_clk(15);
    check("idle_after_tmo", 32'(link_idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
